// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: per channel a 2-FF synchroniser on {B,A},
// a stability filter, a Gray-code step decoder and a wrap/saturate counter
// with per-channel clear and a sticky illegal-transition flag.
module quad_decoder_multi #(
    parameter int NCH  = 2,
    parameter int CW   = 8,
    parameter int FILT = 4,
    parameter int INIT = 128
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NCH-1:0]    i_enc_a,
    input  logic [NCH-1:0]    i_enc_b,
    input  logic [NCH-1:0]    i_clr,
    input  logic              i_sat_mode,
    output logic [NCH*CW-1:0] o_count,
    output logic [NCH-1:0]    o_step,
    output logic [NCH-1:0]    o_dir,
    output logic [NCH-1:0]    o_err
);

    localparam logic [3:0]    FILT_C = 4'(FILT);
    localparam logic [CW-1:0] INIT_C = CW'(INIT);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [1:0]    r_syncMeta;
        logic [1:0]    r_syncOut;
        logic [1:0]    r_sPrev;
        logic [1:0]    r_filt;
        logic [1:0]    r_filtPrev;
        logic [3:0]    r_filtCnt;
        logic [3:0]    w_filtCntNext;
        logic [1:0]    w_posOld;
        logic [1:0]    w_posNew;
        logic [1:0]    w_posDiff;
        logic          w_up;
        logic          w_down;
        logic          w_illegal;
        logic [CW-1:0] r_count;
        logic [CW-1:0] w_countNext;
        logic          r_step;
        logic          r_dir;
        logic          r_err;

        // Two-flop synchroniser bringing the asynchronous {B,A} pins into the clock domain
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_syncMeta <= 2'b00;
                r_syncOut  <= 2'b00;
            end else begin
                r_syncMeta <= {i_enc_b[gi], i_enc_a[gi]};
                r_syncOut  <= r_syncMeta;
            end
        end

        // Stability counter: restarts at 1 on every new candidate, cleared when the candidate matches the accepted state
        always_comb begin
            if (r_syncOut == r_filt) begin
                w_filtCntNext = 4'd0;
            end else if (r_syncOut != r_sPrev) begin
                w_filtCntNext = 4'd1;
            end else begin
                w_filtCntNext = r_filtCnt + 4'd1;
            end
        end

        // Accept the synchronised state once it has been stable for FILT consecutive samples
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_sPrev   <= 2'b00;
                r_filt    <= 2'b00;
                r_filtCnt <= 4'd0;
            end else begin
                r_sPrev <= r_syncOut;
                if (w_filtCntNext == FILT_C) begin
                    r_filt    <= r_syncOut;
                    r_filtCnt <= 4'd0;
                end else begin
                    r_filtCnt <= w_filtCntNext;
                end
            end
        end

        // Gray position 00,01,11,10 -> 0,1,2,3; +1 is up, -1 is down, +2 means both bits flipped
        always_comb begin
            w_posOld    = {r_filtPrev[1], ^r_filtPrev};
            w_posNew    = {r_filt[1], ^r_filt};
            w_posDiff   = w_posNew - w_posOld;
            w_up        = (w_posDiff == 2'd1);
            w_down      = (w_posDiff == 2'd3);
            w_illegal   = (w_posDiff == 2'd2);
            w_countNext = r_count;
            if (w_up) begin
                if (!(i_sat_mode && (r_count == MAX_C))) begin
                    w_countNext = r_count + ONE_C;
                end
            end else if (w_down) begin
                if (!(i_sat_mode && (r_count == '0))) begin
                    w_countNext = r_count - ONE_C;
                end
            end
        end

        // Apply decoded steps to the counter; a clear in the same cycle wins and swallows the step
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_filtPrev <= 2'b00;
                r_count    <= INIT_C;
                r_step     <= 1'b0;
                r_dir      <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                r_filtPrev <= r_filt;
                if (i_clr[gi]) begin
                    r_count <= INIT_C;
                    r_err   <= 1'b0;
                    r_step  <= 1'b0;
                end else begin
                    r_step <= w_up | w_down;
                    if (w_up | w_down) begin
                        r_count <= w_countNext;
                        r_dir   <= w_up;
                    end
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end

        assign o_count[gi*CW +: CW] = r_count;
        assign o_step[gi]           = r_step;
        assign o_dir[gi]            = r_dir;
        assign o_err[gi]            = r_err;
    end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Self-checking bench for quad_decoder_multi: table-driven rotation vectors
// feed a scoreboard of expected step events, plus hand-written sequences for
// glitches, wrap/saturate, illegal transitions, clear collisions and reset.
`timescale 1ns/1ps
module tb_quad_decoder_multi;

    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int FILT = 4;
    localparam int INIT = 128;
    localparam int LAT  = FILT + 3;
    localparam int HOLD = 10;

    typedef struct {
        int ch;
        bit up;
        bit sat;
        int expCount;
        bit expDir;
    } VecRec;

    typedef struct {
        int            ch;
        int            cyc;
        logic [CW-1:0] count;
        logic          dir;
        logic          err;
    } SbEntry;

    logic              clock = 1'b0;
    logic              resetN;
    logic [NCH-1:0]    encA;
    logic [NCH-1:0]    encB;
    logic [NCH-1:0]    clr;
    logic              satMode;
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0]    step;
    logic [NCH-1:0]    dir;
    logic [NCH-1:0]    err;

    int     cyc = 0;
    int     nCompare = 0;
    int     nMiss = 0;
    SbEntry sbQueue [$];
    SbEntry monEntry;
    VecRec  vecs [15];
    logic [1:0] curAb [NCH];
    bit     expErr [NCH];

    quad_decoder_multi #(.NCH(NCH), .CW(CW), .FILT(FILT), .INIT(INIT)) dut (
        .i_clk      (clock),
        .i_reset_n  (resetN),
        .i_enc_a    (encA),
        .i_enc_b    (encB),
        .i_clr      (clr),
        .i_sat_mode (satMode),
        .o_count    (count),
        .o_step     (step),
        .o_dir      (dir),
        .o_err      (err)
    );

    // Free-running clock and a cycle counter used to time-stamp expected steps
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Hard stop in case something hangs the sequence
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 400us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Forward rotation order 00->01->11->10->00
    function automatic logic [1:0] nextUp(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] nextDown(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompare++;
        if (actual != expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setPins(input int ch, input logic [1:0] ab);
        encB[ch]  = ab[1];
        encA[ch]  = ab[0];
        curAb[ch] = ab;
    endtask

    task automatic pushSb(input int ch, input int when, input int expCount, input bit expDir);
        SbEntry e;
        e.ch    = ch;
        e.cyc   = when;
        e.count = CW'(expCount);
        e.dir   = expDir;
        e.err   = expErr[ch];
        sbQueue.push_back(e);
    endtask

    // Move one channel by one detent at a falling edge; optionally record the step it must produce
    task automatic applyStimulus(input int ch, input bit up, input bit sat, input int expCount,
                                 input bit expDir, input bit pushExp, input int hold);
        @(negedge clock);
        satMode = sat;
        setPins(ch, up ? nextUp(curAb[ch]) : nextDown(curAb[ch]));
        if (pushExp) pushSb(ch, cyc + LAT, expCount, expDir);
        repeat (hold) @(negedge clock);
    endtask

    // Scoreboard monitor: every step pulse must match the oldest expectation, and expectations may not go overdue
    always @(negedge clock) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (step[ch] === 1'b1) begin
                nCompare++;
                if (sbQueue.size() == 0) begin
                    nMiss++;
                    $display("[TB] FAIL unexpected step ch%0d at cycle %0d: got step=1 count=%0d, expected no step",
                             ch, cyc, count[ch*CW +: CW]);
                end else begin
                    monEntry = sbQueue.pop_front();
                    if (monEntry.ch != ch || monEntry.cyc != cyc ||
                        count[ch*CW +: CW] !== monEntry.count ||
                        dir[ch] !== monEntry.dir || err[ch] !== monEntry.err) begin
                        nMiss++;
                        $display("[TB] FAIL step ch%0d: got cyc=%0d count=%0d dir=%0b err=%0b, expected ch%0d cyc=%0d count=%0d dir=%0b err=%0b",
                                 ch, cyc, count[ch*CW +: CW], dir[ch], err[ch],
                                 monEntry.ch, monEntry.cyc, monEntry.count, monEntry.dir, monEntry.err);
                    end
                end
            end
        end
        if (sbQueue.size() > 0 && sbQueue[0].cyc < cyc) begin
            monEntry = sbQueue.pop_front();
            nCompare++;
            nMiss++;
            $display("[TB] FAIL missing step ch%0d: got no step by cycle %0d, expected step at cycle %0d count=%0d",
                     monEntry.ch, cyc, monEntry.cyc, monEntry.count);
        end
    end

    initial begin
        // Rotation table: channel, direction, sat_mode, expected count and dir after the step
        vecs[0]  = '{0, 1'b1, 1'b0, 129, 1'b1};
        vecs[1]  = '{0, 1'b1, 1'b0, 130, 1'b1};
        vecs[2]  = '{0, 1'b1, 1'b0, 131, 1'b1};
        vecs[3]  = '{0, 1'b1, 1'b0, 132, 1'b1};
        vecs[4]  = '{1, 1'b0, 1'b0, 127, 1'b0};
        vecs[5]  = '{1, 1'b0, 1'b0, 126, 1'b0};
        vecs[6]  = '{1, 1'b0, 1'b0, 125, 1'b0};
        vecs[7]  = '{1, 1'b0, 1'b0, 124, 1'b0};
        vecs[8]  = '{0, 1'b0, 1'b0, 131, 1'b0};
        vecs[9]  = '{0, 1'b1, 1'b0, 132, 1'b1};
        vecs[10] = '{0, 1'b1, 1'b1, 255, 1'b1};
        vecs[11] = '{0, 1'b1, 1'b0, 0,   1'b1};
        vecs[12] = '{0, 1'b0, 1'b1, 0,   1'b0};
        vecs[13] = '{0, 1'b0, 1'b0, 255, 1'b0};
        vecs[14] = '{0, 1'b1, 1'b0, 0,   1'b1};

        resetN  = 1'b0;
        encA    = '0;
        encB    = '0;
        clr     = '0;
        satMode = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            curAb[ch]  = 2'b00;
            expErr[ch] = 1'b0;
        end

        // Reset held while the pins toggle: everything must sit at reset values
        repeat (6) begin
            @(negedge clock);
            encA = ~encA;
            encB = encB ^ 2'b01;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput($sformatf("reset count ch%0d", ch), count[ch*CW +: CW], INIT);
            checkOutput($sformatf("reset step ch%0d", ch), step[ch], 0);
            checkOutput($sformatf("reset dir ch%0d", ch), dir[ch], 0);
            checkOutput($sformatf("reset err ch%0d", ch), err[ch], 0);
        end
        encA = '0;
        encB = '0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (5) @(negedge clock);

        // Four up detents on ch0, then ch1 down and a reversal on ch0
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].up, vecs[i].sat, vecs[i].expCount, vecs[i].expDir, 1'b1, HOLD);
            if (i == 3) begin
                checkOutput("up4 count ch0", count[CW-1:0], 132);
                checkOutput("up4 dir ch0", dir[0], 1);
                checkOutput("up4 count ch1", count[2*CW-1:CW], 128);
            end
        end
        checkOutput("down4 count ch1", count[2*CW-1:CW], 124);

        // Three-cycle glitch on A must be filtered out completely
        @(negedge clock);
        encA[0] = 1'b1;
        repeat (3) @(negedge clock);
        encA[0] = 1'b0;
        repeat (15) @(negedge clock);
        checkOutput("glitch3 count ch0", count[CW-1:0], 132);

        // Four-cycle pulse is just long enough: one step up, then one step back down
        setPins(0, 2'b01);
        pushSb(0, cyc + LAT, 133, 1'b1);
        repeat (4) @(negedge clock);
        setPins(0, 2'b00);
        pushSb(0, cyc + LAT, 132, 1'b0);
        repeat (12) @(negedge clock);
        checkOutput("glitch4 count ch0", count[CW-1:0], 132);
        checkOutput("glitch4 dir ch0", dir[0], 0);

        // Walk ch0 up to the top of the range
        for (int k = 0; k < 123; k++) begin
            applyStimulus(0, 1'b1, 1'b0, 133 + k, 1'b1, 1'b1, 8);
        end
        checkOutput("runup count ch0", count[CW-1:0], 255);

        // Saturate and wrap corners at both ends
        for (int i = 10; i < 15; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].up, vecs[i].sat, vecs[i].expCount, vecs[i].expDir, 1'b1, HOLD);
        end
        satMode = 1'b0;

        // Illegal jump 00->11: sticky err, no count change
        @(negedge clock);
        setPins(0, 2'b11);
        expErr[0] = 1'b1;
        repeat (HOLD) @(negedge clock);
        checkOutput("illegal err ch0", err[0], 1);
        checkOutput("illegal count ch0", count[CW-1:0], 0);
        checkOutput("illegal dir ch0", dir[0], 1);
        clr[0] = 1'b1;
        @(negedge clock);
        clr[0] = 1'b0;
        expErr[0] = 1'b0;
        @(negedge clock);
        checkOutput("clr count ch0", count[CW-1:0], 128);
        checkOutput("clr err ch0", err[0], 0);
        checkOutput("clr dir ch0", dir[0], 1);

        // Illegal jump 11->00 decoded in the same cycle as clr: err stays clear
        setPins(0, 2'b00);
        repeat (LAT - 1) @(negedge clock);
        clr[0] = 1'b1;
        @(negedge clock);
        clr[0] = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("illegal+clr err ch0", err[0], 0);

        // Step colliding with clr: clr wins and the transition is consumed
        applyStimulus(0, 1'b1, 1'b0, 129, 1'b1, 1'b1, HOLD);
        setPins(0, nextUp(curAb[0]));
        repeat (LAT - 1) @(negedge clock);
        clr[0] = 1'b1;
        @(negedge clock);
        clr[0] = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("collide count ch0", count[CW-1:0], 128);
        checkOutput("collide dir ch0", dir[0], 1);

        // Asynchronous reset mid-filter; ch1 left resting at 11 across the release
        applyStimulus(0, 1'b1, 1'b0, 129, 1'b1, 1'b1, HOLD);
        setPins(0, nextUp(curAb[0]));
        repeat (3) @(negedge clock);
        #2;
        resetN = 1'b0;
        setPins(1, 2'b11);
        #1;
        checkOutput("async reset count ch0", count[CW-1:0], 128);
        checkOutput("async reset dir ch0", dir[0], 0);
        checkOutput("async reset count ch1", count[2*CW-1:CW], 128);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        expErr[1] = 1'b1;
        repeat (15) @(negedge clock);
        checkOutput("release err ch1", err[1], 1);
        checkOutput("release count ch1", count[2*CW-1:CW], 128);
        checkOutput("release err ch0", err[0], 0);
        checkOutput("release count ch0", count[CW-1:0], 128);

        // Drain the scoreboard; anything left over never arrived
        for (int k = 0; k < 50 && sbQueue.size() > 0; k++) @(negedge clock);
        while (sbQueue.size() > 0) begin
            monEntry = sbQueue.pop_front();
            nCompare++;
            nMiss++;
            $display("[TB] FAIL leftover step ch%0d: got nothing, expected count=%0d at cycle %0d",
                     monEntry.ch, monEntry.count, monEntry.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nCompare, nMiss);
        $finish;
    end

endmodule
